uart_rx_cfg: RTL

Parametrised, runtime-configurable UART receiver with an on-chip receive FIFO and a coded error channel. It oversamples the serial line on the single system clock, recovers 5..DATA_W-bit frames with optional parity and 1 or 2 stop bits, and presents received words through a valid/ready stream. It is the drop-in successor to the current fixed-format receiver and runs with no auxiliary clock.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rx_fifo.sv | 60 ++++++
 rtl/uart_rx_cfg.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the configurable UART receiver.
//   rx_state_t  - receiver FSM states
//   err_code_t  - coded error channel values (framing > parity > overrun)
//   CFG_*       - configuration register addresses
//   PAR_*       - parity mode codes held in the parity register (2'b11 behaves as none)
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_STOP2  = 3'd5,
    ST_BREAK  = 3'd6
  } rx_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_FRAME   = 2'b01,
    ERR_PARITY  = 2'b10,
    ERR_OVERRUN = 2'b11
  } err_code_t;

  localparam logic [3:0] CFG_LEN  = 4'd4;
  localparam logic [3:0] CFG_PAR  = 4'd5;
  localparam logic [3:0] CFG_STOP = 4'd6;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive FIFO.
//   clk, rst        - clock, asynchronous active-high reset (pointers/count only)
//   push, push_data - write request and word; ignored when full unless popping
//   pop             - consumer accept; only acts while valid
//   head            - current head word, zero when empty
//   valid, full     - occupancy flags
//   count           - words held (0..DEPTH)
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count_q != '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & valid;
  // When full, the slot being written is the head being popped this cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = valid ? mem[rd_ptr] : '0;
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with runtime frame format and receive FIFO.
//   clk, rst            - system clock, asynchronous active-high reset
//   in                  - serial line (idle high, asynchronous)
//   c_valid/c_addr/c_data/c_ready - config writes, accepted only while idle
//   out/valid_out/ready_out       - FWFT stream of received words
//   error/valid_error   - one-cycle coded error pulse at frame completion
//   fifo_count          - words currently buffered
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in,
  input  logic                         c_valid,
  input  logic [3:0]                   c_addr,
  input  logic [7:0]                   c_data,
  output logic                         c_ready,
  output logic [DATA_W-1:0]            out,
  output logic                         valid_out,
  input  logic                         ready_out,
  output logic [1:0]                   error,
  output logic                         valid_error,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_S0  = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] T_S1  = TW'(OVERSAMPLE/2);
  localparam logic [TW-1:0] T_C   = TW'(OVERSAMPLE/2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [3:0] LEN_MIN = 4'd5;
  localparam logic [3:0] LEN_MAX = 4'(DATA_W);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  rx_state_t         state_q, state_d;
  logic              rx_p0, rx_p1, rx_p2;
  logic [3:0]        len_q;
  logic [1:0]        par_q;
  logic              stop2_q;
  logic [TW-1:0]     tick_q;
  logic [3:0]        bit_cnt_q;
  logic              smp_a, smp_b;
  logic [DATA_W-1:0] data_sr;
  logic              par_acc;
  logic              bit_val, par_on, par_odd, done;
  logic              done_p3, ferr_p3, perr_p3;
  logic [DATA_W-1:0] word_p3;
  logic              clean, pop, push, overrun, fifo_full;
  err_code_t         err_code;
  logic              cfg_unused;

  assign cfg_unused = ^c_data[7:4];
  assign c_ready    = (state_q == ST_IDLE);
  assign par_on     = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
  assign par_odd    = (par_q == PAR_ODD);
  // Third sample is taken live so the decision lands on the centre+1 tick.
  assign bit_val    = maj3(smp_a, smp_b, rx_p1);

  // Stage p0..p2: line synchroniser plus one delay for falling-edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= in;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q   <= LEN_MAX;
      par_q   <= PAR_NONE;
      stop2_q <= 1'b0;
    end else if (c_valid && c_ready) begin
      case (c_addr)
        CFG_LEN:  if (c_data[3:0] >= LEN_MIN && c_data[3:0] <= LEN_MAX) len_q <= c_data[3:0];
        CFG_PAR:  par_q   <= c_data[1:0];
        CFG_STOP: stop2_q <= c_data[0];
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE:   if (rx_p2 && !rx_p1) state_d = ST_START;
      ST_START: begin
        if (tick_q == T_C && bit_val) state_d = ST_IDLE;
        else if (tick_q == T_END)     state_d = ST_DATA;
      end
      ST_DATA:   if (tick_q == T_END && bit_cnt_q == len_q - 4'd1)
                   state_d = par_on ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick_q == T_END) state_d = ST_STOP;
      ST_STOP: begin
        if (tick_q == T_C) begin
          if (!bit_val) begin
            state_d = ST_BREAK;
            done    = 1'b1;
          end else if (!stop2_q) begin
            state_d = ST_IDLE;
            done    = 1'b1;
          end
        end else if (tick_q == T_END) begin
          state_d = ST_STOP2;
        end
      end
      ST_STOP2: begin
        if (tick_q == T_C) begin
          done    = 1'b1;
          state_d = bit_val ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK:  if (rx_p1) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Tick counter restarts every bit period; bit counter only runs in DATA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q    <= '0;
      bit_cnt_q <= '0;
    end else begin
      if (state_q == ST_IDLE || state_q == ST_BREAK || tick_q == T_END) tick_q <= '0;
      else tick_q <= tick_q + 1'b1;
      if (state_q != ST_DATA)  bit_cnt_q <= '0;
      else if (tick_q == T_END) bit_cnt_q <= bit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tick_q == T_S0) smp_a <= rx_p1;
    if (tick_q == T_S1) smp_b <= rx_p1;
    // Clearing in IDLE keeps bits above the configured length at zero.
    if (state_q == ST_IDLE) begin
      data_sr <= '0;
      par_acc <= 1'b0;
    end else if (tick_q == T_C && (state_q == ST_DATA || state_q == ST_PARITY)) begin
      par_acc <= par_acc ^ bit_val;
      if (state_q == ST_DATA)
        for (int i = 0; i < DATA_W; i++)
          if (bit_cnt_q == 4'(i)) data_sr[i] <= bit_val;
    end
    // Stage p3: frame completion, one cycle after the last stop-bit sample
    word_p3 <= data_sr;
    ferr_p3 <= ~bit_val;
    perr_p3 <= par_on & (par_acc ^ par_odd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_p3 <= 1'b0;
    else     done_p3 <= done;
  end

  assign clean       = done_p3 & ~ferr_p3 & ~perr_p3;
  assign pop         = valid_out & ready_out;
  assign push        = clean & (~fifo_full | pop);
  assign overrun     = clean & fifo_full & ~pop;
  assign valid_error = done_p3 & (ferr_p3 | perr_p3 | overrun);

  always_comb begin
    err_code = ERR_NONE;
    if (ferr_p3)      err_code = ERR_FRAME;
    else if (perr_p3) err_code = ERR_PARITY;
    else if (overrun) err_code = ERR_OVERRUN;
  end

  assign error = valid_error ? err_code : ERR_NONE;

  uart_rx_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (word_p3),
    .pop       (ready_out),
    .head      (out),
    .valid     (valid_out),
    .full      (fifo_full),
    .count     (fifo_count)
  );

endmodule
